// File: rtl/riscv_fetch_btb.sv
// RV32I fetch stage: PC register, I-memory address, direct-mapped BTB predictor and IF/ID register.
// Optional macro BTB_2BIT_CTR_EN selects 2-bit saturating counters; default is a 1-bit last-outcome bit.
module riscv_fetch_btb #(
  parameter int              PC_W        = 12,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_PC    = 12'h000
) (
  input  logic            CLK,
  input  logic            RSTn,
  output logic            I_MEM_CSN,
  output logic [PC_W-1:0] I_MEM_ADDR,
  input  logic [31:0]     I_MEM_DI,
  input  logic            pcWrite,
  input  logic            IF_ID_WE,
  input  logic            misPredict,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  output logic [31:0]     INST_IF_ID,
  output logic [PC_W-1:0] pc_IF_ID,
  output logic            valid_IF_ID,
  output logic            pred_IF_ID,
  output logic [PC_W-1:0] ptgt_IF_ID
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
`ifdef BTB_2BIT_CTR_EN
  localparam int               CTR_W     = 2;
  localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
`else
  localparam int               CTR_W     = 1;
  localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
`endif
  localparam logic [31:0] NOP = 32'h00000013;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_nxt;
  logic             btb_valid [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag   [BTB_ENTRIES];
  logic [PC_W-1:0]  btb_tgt   [BTB_ENTRIES];
  logic [CTR_W-1:0] btb_ctr   [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] up_tag;
  logic             lk_hit;
  logic             up_hit;
  logic             pred;
  logic [PC_W-1:0]  pred_tgt;
  logic             unused_upd_lsb;

  // Word-alignment bits of upd_pc take no part in indexing or tagging.
  assign unused_upd_lsb = ^upd_pc[1:0];

  assign I_MEM_CSN  = ~RSTn;
  assign I_MEM_ADDR = pc;

  assign lk_idx   = pc[IDX_W+1:2];
  assign lk_tag   = pc[PC_W-1:IDX_W+2];
  assign lk_hit   = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  // MSB of the counter is the taken decision for both counter widths.
  assign pred     = lk_hit && btb_ctr[lk_idx][CTR_W-1];
  assign pred_tgt = btb_tgt[lk_idx];

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX_W+2];
  assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

  // Saturating step; with a 1-bit counter this reduces to "last outcome".
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic tk);
    logic [CTR_W-1:0] r;
    r = c;
    if (tk && (c != '1))       r = c + CTR_W'(1);
    else if (!tk && (c != '0)) r = c - CTR_W'(1);
    return r;
  endfunction

  always_comb begin
    pc_nxt = pc + PC_W'(4);
    if (misPredict)    pc_nxt = redirect_pc;
    else if (!pcWrite) pc_nxt = pc;
    else if (pred)     pc_nxt = pred_tgt;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) pc <= RESET_PC;
    else       pc <= pc_nxt;
  end

  // Updates land on the clock edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_tag[i]   <= '0;
        btb_tgt[i]   <= '0;
        btb_ctr[i]   <= '0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        btb_ctr[up_idx] <= ctr_step(btb_ctr[up_idx], upd_taken);
        if (upd_taken) btb_tgt[up_idx] <= upd_target;
      end else if (upd_taken) begin
        btb_valid[up_idx] <= 1'b1;
        btb_tag[up_idx]   <= up_tag;
        btb_tgt[up_idx]   <= upd_target;
        btb_ctr[up_idx]   <= CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      INST_IF_ID  <= NOP;
      pc_IF_ID    <= '0;
      valid_IF_ID <= 1'b0;
      pred_IF_ID  <= 1'b0;
      ptgt_IF_ID  <= '0;
    end else if (misPredict) begin
      INST_IF_ID  <= NOP;
      pc_IF_ID    <= '0;
      valid_IF_ID <= 1'b0;
      pred_IF_ID  <= 1'b0;
      ptgt_IF_ID  <= '0;
    end else if (IF_ID_WE) begin
      INST_IF_ID  <= I_MEM_DI;
      pc_IF_ID    <= pc;
      valid_IF_ID <= 1'b1;
      pred_IF_ID  <= pred;
      ptgt_IF_ID  <= pred ? pred_tgt : '0;
    end
  end
endmodule

// File: tb/tb_riscv_fetch_btb.sv
// Self-checking bench for riscv_fetch_btb: directed scenarios followed by randomized traffic,
// all compared against a word-address-level BTB/pipeline model.
module tb_riscv_fetch_btb;
  localparam int PC_W = 12;
  localparam int N    = 16;
`ifdef BTB_2BIT_CTR_EN
  localparam int CMAX   = 3;
  localparam int CALLOC = 2;
  localparam int T3_PRED1 = 1;
  localparam int T3_ADDR1 = 'h040;
`else
  localparam int CMAX   = 1;
  localparam int CALLOC = 1;
  localparam int T3_PRED1 = 0;
  localparam int T3_ADDR1 = 'h014;
`endif
  localparam int TAKEN_MIN = (CMAX + 1) / 2;

  // clock / reset
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic            I_MEM_CSN;
  logic [PC_W-1:0] I_MEM_ADDR;
  logic [31:0]     I_MEM_DI;
  logic            pcWrite, IF_ID_WE, misPredict, upd_valid, upd_taken;
  logic [PC_W-1:0] redirect_pc, upd_pc, upd_target;
  logic [31:0]     INST_IF_ID;
  logic [PC_W-1:0] pc_IF_ID, ptgt_IF_ID;
  logic            valid_IF_ID, pred_IF_ID;

  riscv_fetch_btb dut (
    .CLK(CLK), .RSTn(RSTn), .I_MEM_CSN(I_MEM_CSN), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_DI(I_MEM_DI),
    .pcWrite(pcWrite), .IF_ID_WE(IF_ID_WE), .misPredict(misPredict), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .INST_IF_ID(INST_IF_ID), .pc_IF_ID(pc_IF_ID), .valid_IF_ID(valid_IF_ID),
    .pred_IF_ID(pred_IF_ID), .ptgt_IF_ID(ptgt_IF_ID)
  );

  // instruction memory: each address returns a distinct word
  assign I_MEM_DI = {I_MEM_ADDR, 8'h5A, ~I_MEM_ADDR};

  int n_vec = 0;
  int n_err = 0;

  // reference model: each BTB slot remembers the word address that owns it
  bit          m_bv    [N];
  int          m_bline [N];
  int          m_btgt  [N];
  int          m_bctr  [N];
  int          m_pc;
  logic [31:0] m_inst;
  int          m_pcid;
  bit          m_vld;
  bit          m_pred;
  int          m_ptgt;

  function automatic logic [31:0] mem_word(input int a);
    logic [11:0] w;
    w = a[11:0];
    return {w, 8'h5A, ~w};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bv[i] = 0; m_bline[i] = 0; m_btgt[i] = 0; m_bctr[i] = 0;
    end
    m_pc = 0; m_inst = 32'h00000013; m_pcid = 0; m_vld = 0; m_pred = 0; m_ptgt = 0;
  endtask

  task automatic model_step(input bit mp, input int rpc, input bit pw, input bit we,
                            input bit uv, input int upc, input int utgt, input bit utk);
    int  li, ui;
    bit  p, uhit;
    li = (m_pc >> 2) % N;
    p  = m_bv[li] && (m_bline[li] == (m_pc >> 2)) && (m_bctr[li] >= TAKEN_MIN);
    if (mp) begin
      m_inst = 32'h00000013; m_pcid = 0; m_vld = 0; m_pred = 0; m_ptgt = 0;
    end else if (we) begin
      m_inst = mem_word(m_pc); m_pcid = m_pc; m_vld = 1; m_pred = p;
      m_ptgt = p ? m_btgt[li] : 0;
    end
    if (mp)       m_pc = rpc;
    else if (!pw) m_pc = m_pc;
    else if (p)   m_pc = m_btgt[li];
    else          m_pc = (m_pc + 4) % 4096;
    if (uv) begin
      ui   = (upc >> 2) % N;
      uhit = m_bv[ui] && (m_bline[ui] == (upc >> 2));
      if (uhit) begin
        if (utk) begin
          m_bctr[ui] = (m_bctr[ui] < CMAX) ? m_bctr[ui] + 1 : CMAX;
          m_btgt[ui] = utgt;
        end else begin
          m_bctr[ui] = (m_bctr[ui] > 0) ? m_bctr[ui] - 1 : 0;
        end
      end else if (utk) begin
        m_bv[ui] = 1; m_bline[ui] = upc >> 2; m_btgt[ui] = utgt; m_bctr[ui] = CALLOC;
      end
    end
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_csn"},   32'(I_MEM_CSN),   32'(!RSTn));
    check({tag, "_addr"},  32'(I_MEM_ADDR),  m_pc);
    check({tag, "_inst"},  INST_IF_ID,       m_inst);
    check({tag, "_valid"}, 32'(valid_IF_ID), 32'(m_vld));
    check({tag, "_pred"},  32'(pred_IF_ID),  32'(m_pred));
    check({tag, "_ptgt"},  32'(ptgt_IF_ID),  m_ptgt);
    if (m_vld) check({tag, "_pcid"}, 32'(pc_IF_ID), m_pcid);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_csn"},   32'(I_MEM_CSN),   32'd1);
    check({tag, "_addr"},  32'(I_MEM_ADDR),  32'h000);
    check({tag, "_inst"},  INST_IF_ID,       32'h00000013);
    check({tag, "_pcid"},  32'(pc_IF_ID),    32'h000);
    check({tag, "_valid"}, 32'(valid_IF_ID), 32'd0);
    check({tag, "_pred"},  32'(pred_IF_ID),  32'd0);
    check({tag, "_ptgt"},  32'(ptgt_IF_ID),  32'h000);
  endtask

  // driver: apply one cycle of inputs, advance the model, then check after the edge
  task automatic cyc(input bit mp, input int rpc, input bit pw, input bit we,
                     input bit uv, input int upc, input int utgt, input bit utk, input string tag);
    misPredict  = mp;
    redirect_pc = rpc[PC_W-1:0];
    pcWrite     = pw;
    IF_ID_WE    = we;
    upd_valid   = uv;
    upd_pc      = upc[PC_W-1:0];
    upd_target  = utgt[PC_W-1:0];
    upd_taken   = utk;
    model_step(mp, rpc, pw, we, uv, upc, utgt, utk);
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(0, 0, 1, 1, 0, 0, 0, 0, tag);
  endtask

  initial begin
    bit mp, pw, we, uv, utk;
    int rpc, upc, utgt;

    misPredict = 0; redirect_pc = '0; pcWrite = 1; IF_ID_WE = 1;
    upd_valid = 0; upd_pc = '0; upd_target = '0; upd_taken = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_vals("rst");
    RSTn = 1'b1;

    // T1: sequential fetch
    idle("t1");
    check("t1_first_pcid",  32'(pc_IF_ID),    32'h000);
    check("t1_first_valid", 32'(valid_IF_ID), 32'd1);
    check("t1_first_addr",  32'(I_MEM_ADDR),  32'h004);
    for (int i = 0; i < 4; i++) begin
      idle("t1");
      check("t1_step_addr", 32'(I_MEM_ADDR), 32'(4 * (i + 2)));
      check("t1_no_pred",   32'(pred_IF_ID), 32'd0);
    end

    // T2: allocate 0x010 -> 0x040 while redirecting to 0x008, then fetch through 0x010
    cyc(1, 'h008, 1, 1, 1, 'h010, 'h040, 1, "t2_alloc");
    idle("t2");
    idle("t2");
    idle("t2_hit");
    check("t2_pcid", 32'(pc_IF_ID),   32'h010);
    check("t2_pred", 32'(pred_IF_ID), 32'd1);
    check("t2_ptgt", 32'(ptgt_IF_ID), 32'h040);
    check("t2_addr", 32'(I_MEM_ADDR), 32'h040);

    // T3: strengthen then weaken the 0x010 entry
    cyc(0, 0, 0, 0, 1, 'h010, 'h040, 1, "t3_up");
    cyc(0, 0, 0, 0, 1, 'h010, 'h040, 0, "t3_nt1");
    cyc(1, 'h010, 1, 1, 0, 0, 0, 0, "t3_redir");
    idle("t3_fetch1");
    check("t3_pred1", 32'(pred_IF_ID), 32'(T3_PRED1));
    check("t3_addr1", 32'(I_MEM_ADDR), 32'(T3_ADDR1));
    cyc(1, 'h010, 1, 1, 1, 'h010, 'h040, 0, "t3_nt2");
    idle("t3_fetch2");
    check("t3_pred2", 32'(pred_IF_ID), 32'd0);
    check("t3_addr2", 32'(I_MEM_ADDR), 32'h014);

    // T4: stall with a redirect in the middle
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "t4_c1");
    check("t4_hold_addr", 32'(I_MEM_ADDR), 32'h014);
    check("t4_hold_pcid", 32'(pc_IF_ID),   32'h010);
    cyc(1, 'h100, 0, 0, 0, 0, 0, 0, "t4_c2");
    check("t4_squash_inst",  INST_IF_ID,       32'h00000013);
    check("t4_squash_valid", 32'(valid_IF_ID), 32'd0);
    check("t4_redir_addr",   32'(I_MEM_ADDR),  32'h100);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "t4_c3");
    check("t4_c3_addr", 32'(I_MEM_ADDR), 32'h100);

    // T5: wrap from 0xFFC
    cyc(1, 'hFFC, 1, 1, 0, 0, 0, 0, "t5_redir");
    idle("t5_wrap");
    check("t5_wrap_addr", 32'(I_MEM_ADDR), 32'h000);
    check("t5_wrap_pcid", 32'(pc_IF_ID),   32'hFFC);

    // T6: 0x050 aliases 0x010 and evicts it
    cyc(0, 0, 0, 0, 1, 'h010, 'h080, 1, "t6_a");
    cyc(0, 0, 0, 0, 1, 'h050, 'h0C0, 1, "t6_b");
    cyc(1, 'h010, 1, 1, 0, 0, 0, 0, "t6_r1");
    idle("t6_f1");
    check("t6_alias_pred", 32'(pred_IF_ID), 32'd0);
    check("t6_alias_addr", 32'(I_MEM_ADDR), 32'h014);
    cyc(1, 'h050, 1, 1, 0, 0, 0, 0, "t6_r2");
    idle("t6_f2");
    check("t6_new_pred", 32'(pred_IF_ID), 32'd1);
    check("t6_new_ptgt", 32'(ptgt_IF_ID), 32'h0C0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "t6_stall");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "t6_stall");
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check_reset_vals("t6_async_rst");
    model_reset();
    @(posedge CLK);
    #1;
    check_reset_vals("t6_rst_held");
    RSTn = 1'b1;
    cyc(1, 'h050, 1, 1, 0, 0, 0, 0, "t6_post_redir");
    idle("t6_post_fetch");
    check("t6_btb_cleared", 32'(pred_IF_ID), 32'd0);
    check("t6_post_addr",   32'(I_MEM_ADDR), 32'h054);

    // randomized traffic over a small address pool so entries alias and hit often
    for (int i = 0; i < 400; i++) begin
      mp  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? ('hFF0 + 4 * $urandom_range(0, 3))
                                        : 4 * $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) rpc = rpc | $urandom_range(1, 3);
      pw   = ($urandom_range(0, 5) != 0);
      we   = ($urandom_range(0, 5) != 0);
      uv   = ($urandom_range(0, 2) == 0);
      upc  = 4 * $urandom_range(0, 63);
      utgt = 4 * $urandom_range(0, 63);
      utk  = $urandom_range(0, 1);
      cyc(mp, rpc, pw, we, uv, upc, utgt, utk, "rnd");
      if (i == 200) begin
        #2;
        RSTn = 1'b0;
        #1;
        model_reset();
        check_all("rnd_rst");
        RSTn = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
